// File: rtl/terminal_writer_if.sv
// Keystroke handshake, clear request, character-grid write port and cursor status of terminal_writer.
// slave is the writer side; master is whoever supplies keystrokes and observes the grid port.
interface terminal_writer_if #(
    parameter int SCREEN_WIDTH  = 76,
    parameter int SCREEN_HEIGHT = 44
);
    localparam int AW = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT);
    localparam int XW = $clog2(SCREEN_WIDTH);
    localparam int YW = $clog2(SCREEN_HEIGHT);

    logic          char_valid_in;
    logic [7:0]    char_in;
    logic          char_ready_out;
    logic          clear_in;
    logic          tg_write_en;
    logic [AW-1:0] tg_addr;
    logic [7:0]    tg_input;
    logic [XW-1:0] cursor_x_out;
    logic [YW-1:0] cursor_y_out;
    logic          busy_out;

    modport master (
        output char_valid_in, char_in, clear_in,
        input  char_ready_out, tg_write_en, tg_addr, tg_input,
               cursor_x_out, cursor_y_out, busy_out
    );

    modport slave (
        input  char_valid_in, char_in, clear_in,
        output char_ready_out, tg_write_en, tg_addr, tg_input,
               cursor_x_out, cursor_y_out, busy_out
    );
endinterface

// File: rtl/terminal_writer.sv
// Sole writer of the terminal character grid: keystrokes, cursor, row and screen clears; write appears one cycle after acceptance.
// Keystrokes are back-pressured (ready low) whenever a row/screen clear runs or clear_in is high.
module terminal_writer #(
    parameter int SCREEN_WIDTH   = 76,
    parameter int SCREEN_HEIGHT  = 44,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic             pixel_clk_in,
    input  logic             rst_n_in,
    terminal_writer_if.slave bus
);
    localparam int AW = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT);
    localparam int XW = $clog2(SCREEN_WIDTH);
    localparam int YW = $clog2(SCREEN_HEIGHT);

    localparam logic [AW-1:0] W_A       = AW'(SCREEN_WIDTH);
    localparam logic [AW-1:0] LAST_COL  = AW'(SCREEN_WIDTH - 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(SCREEN_WIDTH * SCREEN_HEIGHT - 1);
    localparam logic [XW-1:0] X_MAX     = XW'(SCREEN_WIDTH - 1);
    localparam logic [YW-1:0] Y_MAX     = YW'(SCREEN_HEIGHT - 1);
    localparam logic [7:0]    SPACE     = 8'd32;

    typedef enum logic [1:0] {IDLE, CLEAR_ROW, CLEAR_ALL} state_t;
    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR_ALL : IDLE;

    state_t        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [AW-1:0] base_q, base_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    data_q, data_d;

    logic          ready;
    logic          printable, is_nl, is_bs;
    logic [AW-1:0] nl_base;
    logic [YW-1:0] nl_y;

    assign ready     = (state_q == IDLE) && !bus.clear_in;
    assign printable = bus.char_in inside {8'd32, [8'd97:8'd122], 8'd40, 8'd41, 8'd60, 8'd61, 8'd62};
    assign is_nl     = (bus.char_in == 8'd10) || (bus.char_in == 8'd13);
    assign is_bs     = (bus.char_in == 8'd8);
    assign nl_base   = (y_q == Y_MAX) ? '0 : base_q + W_A;
    assign nl_y      = (y_q == Y_MAX) ? '0 : y_q + YW'(1);

    // cnt_q is the next position a clear will write; last_q marks that the final position is already on the port.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        if (bus.clear_in) begin
            state_d = CLEAR_ALL;
            x_d     = '0;
            y_d     = '0;
            base_d  = '0;
            we_d    = 1'b1;
            addr_d  = '0;
            data_d  = SPACE;
            cnt_d   = AW'(1);
            last_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.char_valid_in) begin
                        if (printable) begin
                            we_d   = 1'b1;
                            addr_d = base_q + AW'(x_q);
                            data_d = bus.char_in;
                            if (x_q == X_MAX) begin
                                // Wrap: the row clear starts right after this character's write.
                                x_d     = '0;
                                y_d     = nl_y;
                                base_d  = nl_base;
                                state_d = CLEAR_ROW;
                                cnt_d   = '0;
                                last_d  = 1'b0;
                            end else begin
                                x_d = x_q + XW'(1);
                            end
                        end else if (is_nl) begin
                            x_d     = '0;
                            y_d     = nl_y;
                            base_d  = nl_base;
                            state_d = CLEAR_ROW;
                            we_d    = 1'b1;
                            addr_d  = nl_base;
                            data_d  = SPACE;
                            cnt_d   = AW'(1);
                            last_d  = 1'b0;
                        end else if (is_bs) begin
                            if (x_q != '0) begin
                                x_d    = x_q - XW'(1);
                                we_d   = 1'b1;
                                addr_d = base_q + AW'(x_q) - AW'(1);
                                data_d = SPACE;
                            end else if (y_q != '0) begin
                                x_d    = X_MAX;
                                y_d    = y_q - YW'(1);
                                base_d = base_q - W_A;
                                we_d   = 1'b1;
                                addr_d = base_q - AW'(1);
                                data_d = SPACE;
                            end
                        end
                    end
                end
                CLEAR_ROW, CLEAR_ALL: begin
                    if (last_q) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        last_d  = 1'b0;
                    end else begin
                        we_d   = 1'b1;
                        data_d = SPACE;
                        addr_d = (state_q == CLEAR_ROW) ? base_q + cnt_q : cnt_q;
                        last_d = (state_q == CLEAR_ROW) ? (cnt_q == LAST_COL) : (cnt_q == LAST_ADDR);
                        if (!last_d) begin
                            cnt_d = cnt_q + AW'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= RESET_STATE;
            x_q     <= '0;
            y_q     <= '0;
            base_q  <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign bus.char_ready_out = ready;
    assign bus.busy_out       = (state_q != IDLE);
    assign bus.tg_write_en    = we_q;
    assign bus.tg_addr        = addr_q;
    assign bus.tg_input       = data_q;
    assign bus.cursor_x_out   = x_q;
    assign bus.cursor_y_out   = y_q;
endmodule

// File: tb/tb_terminal_writer.sv
// Directed bench for terminal_writer: keystroke vector table plus hand-written clear/wrap/reset sequences.
module tb_terminal_writer;
    localparam int W = 76;
    localparam int H = 44;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    terminal_writer_if #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H)) bus();

    terminal_writer #(
        .SCREEN_WIDTH(W),
        .SCREEN_HEIGHT(H),
        .CLEAR_ON_RESET(1)
    ) dut (
        .pixel_clk_in(clk),
        .rst_n_in(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] ch;
        logic       we;
        int         addr;
        int         dat;
        int         x;
        int         y;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic we, input int addr, input int dat);
        check({name, "_we"}, 32'(bus.tg_write_en), 32'(we));
        if (we) begin
            check({name, "_addr"}, 32'(bus.tg_addr), 32'(addr));
            check({name, "_data"}, 32'(bus.tg_input), 32'(dat));
        end
    endtask

    task automatic check_cursor(input string name, input int x, input int y);
        check({name, "_x"}, 32'(bus.cursor_x_out), 32'(x));
        check({name, "_y"}, 32'(bus.cursor_y_out), 32'(y));
    endtask

    // Expects n consecutive space writes at start..start+n-1 with ready low throughout.
    task automatic check_strobes(input string name, input int start, input int n);
        int bad = 0;
        int bad_idx = 0;
        logic [31:0] bw = 0, ba = 0, bd = 0, br = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (bus.tg_write_en !== 1'b1 || 32'(bus.tg_addr) !== 32'(start + k) ||
                bus.tg_input !== 8'd32 || bus.char_ready_out !== 1'b0) begin
                if (bad == 0) begin
                    bad_idx = k;
                    bw = 32'(bus.tg_write_en);
                    ba = 32'(bus.tg_addr);
                    bd = 32'(bus.tg_input);
                    br = 32'(bus.char_ready_out);
                end
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s: %0d bad cycles, first at %0d got we=%0d addr=%0d data=%0d ready=%0d, required we=1 addr=%0d data=32 ready=0",
                     name, bad, bad_idx, bw, ba, bd, br, start + bad_idx);
        end
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 5000 && bus.char_ready_out !== 1'b1; i++) @(negedge clk);
        check("ready_wait", 32'(bus.char_ready_out), 32'd1);
    endtask

    // Presents one keystroke, returns at the negedge after it was accepted.
    task automatic send_char(input logic [7:0] c);
        wait_ready();
        bus.char_in       = c;
        bus.char_valid_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.char_valid_in = 1'b0;
    endtask

    initial begin
        bus.char_valid_in = 1'b0;
        bus.char_in       = 8'd0;
        bus.clear_in      = 1'b0;
        rst_n             = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_we", 32'(bus.tg_write_en), 32'd0);
        check("rst_addr", 32'(bus.tg_addr), 32'd0);
        check("rst_data", 32'(bus.tg_input), 32'd0);
        check_cursor("rst", 0, 0);
        check("rst_busy", 32'(bus.busy_out), 32'd1);
        check("rst_ready", 32'(bus.char_ready_out), 32'd0);

        rst_n = 1'b1;
        check_strobes("reset_clear", 0, W * H);
        @(negedge clk);
        check("reset_clear_done_ready", 32'(bus.char_ready_out), 32'd1);
        check("reset_clear_done_we", 32'(bus.tg_write_en), 32'd0);
        check("reset_clear_done_busy", 32'(bus.busy_out), 32'd0);
        check_cursor("reset_clear_done", 0, 0);

        // Back-to-back keystrokes from (0,0), one per cycle.
        vecs[0]  = '{8'd97,  1'b1, 0, 97,  1, 0};
        vecs[1]  = '{8'd98,  1'b1, 1, 98,  2, 0};
        vecs[2]  = '{8'd99,  1'b1, 2, 99,  3, 0};
        vecs[3]  = '{8'd65,  1'b0, 0, 0,   3, 0};
        vecs[4]  = '{8'd8,   1'b1, 2, 32,  2, 0};
        vecs[5]  = '{8'd60,  1'b1, 2, 60,  3, 0};
        vecs[6]  = '{8'd62,  1'b1, 3, 62,  4, 0};
        vecs[7]  = '{8'd40,  1'b1, 4, 40,  5, 0};
        vecs[8]  = '{8'd41,  1'b1, 5, 41,  6, 0};
        vecs[9]  = '{8'd61,  1'b1, 6, 61,  7, 0};
        vecs[10] = '{8'd32,  1'b1, 7, 32,  8, 0};
        vecs[11] = '{8'd122, 1'b1, 8, 122, 9, 0};
        vecs[12] = '{8'd200, 1'b0, 0, 0,   9, 0};
        vecs[13] = '{8'd96,  1'b0, 0, 0,   9, 0};
        vecs[14] = '{8'd123, 1'b0, 0, 0,   9, 0};
        vecs[15] = '{8'd8,   1'b1, 8, 32,  8, 0};
        for (int i = 0; i < 16; i++) begin
            bus.char_in       = vecs[i].ch;
            bus.char_valid_in = 1'b1;
            check($sformatf("vec%0d_ready", i), 32'(bus.char_ready_out), 32'd1);
            @(posedge clk);
            @(negedge clk);
            check_out($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].dat);
            check_cursor($sformatf("vec%0d", i), vecs[i].x, vecs[i].y);
        end
        bus.char_valid_in = 1'b0;

        // Line wrap from the last column of row 2.
        send_char(8'd13);
        send_char(8'd13);
        for (int i = 0; i < W - 1; i++) send_char(8'd32);
        check_cursor("pre_wrap", 75, 2);
        send_char(8'd122);
        check_out("wrap_char", 1'b1, 227, 122);
        check_cursor("wrap", 0, 3);
        check("wrap_ready", 32'(bus.char_ready_out), 32'd0);
        check_strobes("wrap_row", 228, W);
        @(negedge clk);
        check("wrap_done_ready", 32'(bus.char_ready_out), 32'd1);
        check("wrap_done_we", 32'(bus.tg_write_en), 32'd0);

        // Newline on the bottom row wraps to row 0.
        for (int i = 0; i < 40; i++) send_char(8'd13);
        for (int i = 0; i < 10; i++) send_char(8'd32);
        check_cursor("bottom", 10, 43);
        send_char(8'd13);
        check_out("bottom_nl", 1'b1, 0, 32);
        check_cursor("bottom_nl", 0, 0);
        check_strobes("top_row", 1, W - 1);
        @(negedge clk);
        check("top_row_done_ready", 32'(bus.char_ready_out), 32'd1);

        // Backspace from column 0 goes to the end of the previous row.
        for (int i = 0; i < 5; i++) send_char(8'd13);
        check_cursor("row5", 0, 5);
        send_char(8'd8);
        check_out("bs_up", 1'b1, 379, 32);
        check_cursor("bs_up", 75, 4);

        // clear_in aborts a row clear; a held keystroke waits until the screen clear completes.
        send_char(8'd13);
        check_out("row5_first", 1'b1, 380, 32);
        repeat (30) @(negedge clk);
        check("row5_col30_addr", 32'(bus.tg_addr), 32'd410);
        bus.clear_in      = 1'b1;
        bus.char_in       = 8'd113;
        bus.char_valid_in = 1'b1;
        #1;
        check("clear_pulse_ready", 32'(bus.char_ready_out), 32'd0);
        @(negedge clk);
        bus.clear_in = 1'b0;
        check_out("abort_first", 1'b1, 0, 32);
        check_cursor("abort_first", 0, 0);
        check_strobes("abort_clear", 1, W * H - 1);
        check_cursor("abort_end", 0, 0);
        @(negedge clk);
        check("abort_done_we", 32'(bus.tg_write_en), 32'd0);
        check("abort_done_ready", 32'(bus.char_ready_out), 32'd1);
        @(negedge clk);
        bus.char_valid_in = 1'b0;
        check_out("held_char", 1'b1, 0, 113);
        check_cursor("held_char", 1, 0);

        send_char(8'd8);
        check_out("bs_first", 1'b1, 0, 32);
        check_cursor("bs_first", 0, 0);
        send_char(8'd8);
        check("bs_origin_we", 32'(bus.tg_write_en), 32'd0);
        check_cursor("bs_origin", 0, 0);
        send_char(8'd65);
        check("drop_we", 32'(bus.tg_write_en), 32'd0);
        check("drop_ready", 32'(bus.char_ready_out), 32'd1);
        check_cursor("drop", 0, 0);

        // Asynchronous reset in the middle of a screen clear.
        bus.clear_in = 1'b1;
        @(negedge clk);
        bus.clear_in = 1'b0;
        repeat (1000) @(negedge clk);
        check("mid_clear_addr", 32'(bus.tg_addr), 32'd1000);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_we", 32'(bus.tg_write_en), 32'd0);
        check("async_rst_addr", 32'(bus.tg_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check_strobes("restart_clear", 0, W * H);
        @(negedge clk);
        check("restart_done_ready", 32'(bus.char_ready_out), 32'd1);
        check_cursor("restart_done", 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
